// File: rtl/conv_pkg.sv
// Shared conv-pipeline definitions: default geometry, sample width and the
// row-phase state encoding used by the pooling stage.
package conv_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int FM_W_DEF   = 10;
    localparam int FM_H_DEF   = 10;
    localparam int FM_C_DEF   = 12;

    // Row-phase states of the 2x2 pooling walker.
    typedef logic [0:0] row_state_t;
    localparam row_state_t ROW_EVEN = 1'b0;
    localparam row_state_t ROW_ODD  = 1'b1;

    // Counter width able to hold 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/relu_maxpool_if.sv
// Stream bundle around the pooling stage: sample input, pooled output and
// the per-frame ReLU enable.
interface relu_maxpool_if import conv_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              relu_en;
    logic              din_valid;
    logic              din_ready;
    logic [DATA_W-1:0] din_data;
    logic              dout_valid;
    logic              dout_ready;
    logic [DATA_W-1:0] dout_data;
    logic              dout_last;

    modport master (
        output relu_en, din_valid, din_data, dout_ready,
        input  din_ready, dout_valid, dout_data, dout_last
    );

    modport slave (
        input  relu_en, din_valid, din_data, dout_ready,
        output din_ready, dout_valid, dout_data, dout_last
    );

endinterface

// File: rtl/pool_linebuf.sv
// Half-row line buffer holding the horizontal pair maxima of an even row
// until the matching odd row arrives.
module pool_linebuf import conv_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = FM_W_DEF / 2,
    parameter int AW     = cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // No reset: every entry is rewritten in an even row before it is read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Combinational read so the odd-row window completes in the accept cycle.
    assign rdata = mem[raddr];

endmodule

// File: rtl/relu_maxpool.sv
// ReLU followed by 2x2/stride-2 max pooling over channel-major feature maps,
// with a one-beat output register and pass-through backpressure.
module relu_maxpool import conv_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int FM_W   = FM_W_DEF,
    parameter int FM_H   = FM_H_DEF,
    parameter int FM_C   = FM_C_DEF
) (
    input logic           clk,
    input logic           rst_n,
    relu_maxpool_if.slave bus
);

    localparam int CW       = cnt_w(FM_W);
    localparam int RW       = cnt_w(FM_H);
    localparam int CHW      = cnt_w(FM_C);
    localparam int LB_DEPTH = FM_W / 2;
    localparam int AW       = cnt_w(LB_DEPTH);

    generate
        if ((FM_W % 2) != 0 || (FM_H % 2) != 0 || FM_W < 2 || FM_H < 2) begin : g_bad_geometry
            $error("relu_maxpool: FM_W and FM_H must be even and at least 2");
        end
    endgenerate

    function automatic logic signed [DATA_W-1:0] smax(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    logic [CW-1:0]             col_reg;
    logic [RW-1:0]             row_reg;
    logic [CHW-1:0]            ch_reg;
    row_state_t                state_reg;
    logic signed [DATA_W-1:0]  pair_reg;
    logic [DATA_W-1:0]         dout_data_reg;
    logic                      dout_valid_reg;
    logic                      dout_last_reg;

    logic                      accept;
    logic                      col_last;
    logic                      row_last;
    logic                      ch_last;
    logic                      odd_col;
    logic                      lb_we;
    logic                      produce;
    logic [AW-1:0]             lb_addr;
    logic signed [DATA_W-1:0]  sample;
    logic signed [DATA_W-1:0]  pair_max;
    logic signed [DATA_W-1:0]  lb_rdata;
    logic signed [DATA_W-1:0]  window_max;

    assign bus.din_ready  = !dout_valid_reg || bus.dout_ready;
    assign bus.dout_valid = dout_valid_reg;
    assign bus.dout_data  = dout_data_reg;
    assign bus.dout_last  = dout_last_reg;

    assign accept   = bus.din_valid && bus.din_ready;
    assign col_last = (col_reg == CW'(FM_W - 1));
    assign row_last = (row_reg == RW'(FM_H - 1));
    assign ch_last  = (ch_reg  == CHW'(FM_C - 1));
    assign odd_col  = col_reg[0];
    assign lb_addr  = AW'(col_reg >> 1);
    assign lb_we    = accept && odd_col && (state_reg == ROW_EVEN);
    assign produce  = accept && odd_col && (state_reg == ROW_ODD);

    assign sample     = (bus.relu_en && bus.din_data[DATA_W-1]) ? '0 : $signed(bus.din_data);
    assign pair_max   = smax(pair_reg, sample);
    assign window_max = smax(pair_max, lb_rdata);

    pool_linebuf #(
        .DATA_W (DATA_W),
        .DEPTH  (LB_DEPTH),
        .AW     (AW)
    ) u_linebuf (
        .clk   (clk),
        .we    (lb_we),
        .waddr (lb_addr),
        .wdata (pair_max),
        .raddr (lb_addr),
        .rdata (lb_rdata)
    );

    // Raster position and row phase; the phase flips on every row wrap, so an
    // even FM_H always brings it back to ROW_EVEN at each channel start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_reg   <= '0;
            row_reg   <= '0;
            ch_reg    <= '0;
            state_reg <= ROW_EVEN;
            pair_reg  <= '0;
        end else if (accept) begin
            if (!odd_col) begin
                pair_reg <= sample;
            end
            if (col_last) begin
                col_reg   <= '0;
                state_reg <= (state_reg == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
                if (row_last) begin
                    row_reg <= '0;
                    ch_reg  <= ch_last ? '0 : ch_reg + CHW'(1);
                end else begin
                    row_reg <= row_reg + RW'(1);
                end
            end else begin
                col_reg <= col_reg + CW'(1);
            end
        end
    end

    // A window can only complete when din_ready is high, i.e. the output slot
    // is empty or draining this cycle, so a new beat never overwrites a live one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_valid_reg <= 1'b0;
            dout_last_reg  <= 1'b0;
            dout_data_reg  <= '0;
        end else if (produce) begin
            dout_valid_reg <= 1'b1;
            dout_last_reg  <= ch_last && row_last && col_last;
            dout_data_reg  <= window_max;
        end else if (bus.dout_ready) begin
            dout_valid_reg <= 1'b0;
            dout_last_reg  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_relu_maxpool.sv
// Directed and randomized frames through relu_maxpool, checked against a
// window-by-window pooling model of each frame.
module tb_relu_maxpool;

    localparam int DW = 16;
    localparam int W  = 10;
    localparam int H  = 10;
    localparam int C  = 12;
    localparam int NS = W * H * C;
    localparam int NB = C * (H / 2) * (W / 2);

    typedef struct {
        int data;
        bit last;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    relu_maxpool_if #(.DATA_W(DW)) bus ();

    relu_maxpool #(
        .DATA_W (DW),
        .FM_W   (W),
        .FM_H   (H),
        .FM_C   (C)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    beat_t       exp_q [$];
    int          fr [NS];
    int          n_cmp = 0;
    int          n_err = 0;
    int          frame_pops = 0;
    bit          prev_hold = 1'b0;
    logic [DW-1:0] prev_data;
    logic        prev_last;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pooling model: each 2x2 window of the frame, ReLU applied first.
    function automatic void build_expected(input bit relu);
        for (int c = 0; c < C; c++) begin
            for (int i = 0; i < H / 2; i++) begin
                for (int j = 0; j < W / 2; j++) begin
                    beat_t b;
                    int m = -(1 << 30);
                    for (int dy = 0; dy < 2; dy++) begin
                        for (int dx = 0; dx < 2; dx++) begin
                            int v = fr[c * H * W + (2 * i + dy) * W + 2 * j + dx];
                            if (relu && v < 0) v = 0;
                            if (v > m) m = v;
                        end
                    end
                    b.data = m;
                    b.last = (c == C - 1) && (i == H / 2 - 1) && (j == W / 2 - 1);
                    exp_q.push_back(b);
                end
            end
        end
    endfunction

    // Windows whose last (bottom-right) sample lies within the first n samples.
    function automatic int windows_before(input int n);
        int cnt = 0;
        for (int c = 0; c < C; c++)
            for (int i = 0; i < H / 2; i++)
                for (int j = 0; j < W / 2; j++)
                    if (c * H * W + (2 * i + 1) * W + 2 * j + 1 < n) cnt++;
        return cnt;
    endfunction

    function automatic void fill_random();
        for (int k = 0; k < NS; k++) begin
            logic signed [DW-1:0] t;
            t = DW'($urandom);
            fr[k] = t;
        end
    endfunction

    // rmode: 0 = always ready, 1 = random 50%, 2 = hold ready low 20 cycles at first beat
    task automatic drive(input int n, input int vpct, input int rmode);
        int idx = 0;
        int stall = 0;
        bit first = 1'b1;
        int guard = 0;
        while (idx < n && guard < 20000) begin
            @(negedge clk);
            guard++;
            case (rmode)
                0: bus.dout_ready = 1'b1;
                1: bus.dout_ready = ($urandom_range(0, 99) < 50);
                default: begin
                    if (first && bus.dout_valid === 1'b1) begin
                        first = 1'b0;
                        stall = 20;
                    end
                    bus.dout_ready = (stall == 0);
                    if (stall > 0) stall--;
                end
            endcase
            bus.din_valid = ($urandom_range(0, 99) < vpct);
            bus.din_data  = DW'(fr[idx]);
            #1;
            if (rmode == 2 && !bus.dout_ready) check("stall_din_ready", bus.din_ready, 0);
            if (bus.din_valid && bus.din_ready === 1'b1) idx++;
        end
        check("drive_samples_accepted", idx, n);
        @(negedge clk);
        bus.din_valid  = 1'b0;
        bus.dout_ready = 1'b1;
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        while (exp_q.size() > 0 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        repeat (4) @(negedge clk);
        check(tag, exp_q.size(), 0);
    endtask

    task automatic run_frame(input bit relu, input int vpct, input int rmode, input string tag);
        bus.relu_en = relu;
        frame_pops  = 0;
        build_expected(relu);
        drive(NS, vpct, rmode);
        drain({tag, "_drain"});
        check({tag, "_beats"}, frame_pops, NB);
    endtask

    // Output monitor, sampled mid-cycle after the bench has driven dout_ready.
    always begin
        @(negedge clk);
        #2;
        if (rst_n !== 1'b1) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", bus.dout_valid, 1);
                check("hold_data", $signed(bus.dout_data), $signed(prev_data));
                check("hold_last", bus.dout_last, prev_last);
            end
            if (bus.dout_valid === 1'b1 && bus.dout_ready === 1'b1) begin
                check("beat_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    beat_t b;
                    b = exp_q.pop_front();
                    check("beat_data", $signed(bus.dout_data), b.data);
                    check("beat_last", bus.dout_last, b.last);
                    frame_pops++;
                end
            end
            prev_hold = (bus.dout_valid === 1'b1) && (bus.dout_ready === 1'b0);
            prev_data = bus.dout_data;
            prev_last = bus.dout_last;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n          = 1'b0;
        bus.relu_en    = 1'b0;
        bus.din_valid  = 1'b0;
        bus.din_data   = '0;
        bus.dout_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_dout_valid", bus.dout_valid, 0);
        check("reset_dout_last", bus.dout_last, 0);
        check("reset_dout_data", bus.dout_data, 0);
        check("reset_din_ready", bus.din_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Ramp frame: beat (c,i,j) = c*100 + (2i+1)*10 + 2j+1
        for (int k = 0; k < NS; k++)
            fr[k] = (k / (H * W)) * 100 + ((k / W) % H) * 10 + (k % W);
        run_frame(1'b0, 100, 0, "ramp");

        // All -1.0 with ReLU: every beat 0
        for (int k = 0; k < NS; k++) fr[k] = -1024;
        run_frame(1'b1, 100, 0, "relu_neg");

        // Single negative window among -100, signed compare
        for (int k = 0; k < NS; k++) fr[k] = -100;
        fr[3 * H * W + 4 * W + 2] = -5;
        fr[3 * H * W + 4 * W + 3] = -3;
        fr[3 * H * W + 5 * W + 2] = -7;
        fr[3 * H * W + 5 * W + 3] = -2;
        run_frame(1'b0, 100, 0, "neg_window");

        // Downstream stall on the first beat
        fill_random();
        run_frame(1'b0, 100, 2, "stall");

        // Random valid/ready over three frames
        for (int f = 0; f < 3; f++) begin
            fill_random();
            run_frame(1'($urandom_range(0, 1)), 50, 1, "random");
        end

        // Reset mid-frame after 137 samples, then a full frame
        fill_random();
        bus.relu_en = 1'b0;
        frame_pops  = 0;
        build_expected(1'b0);
        drive(137, 100, 0);
        repeat (3) @(negedge clk);
        check("partial_beats", frame_pops, windows_before(137));
        #3;
        rst_n         = 1'b0;
        bus.din_valid = 1'b1;
        bus.din_data  = DW'(fr[5]);
        #1;
        check("async_rst_dout_valid", bus.dout_valid, 0);
        check("async_rst_dout_data", bus.dout_data, 0);
        check("async_rst_dout_last", bus.dout_last, 0);
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            #1;
            check("in_rst_dout_valid", bus.dout_valid, 0);
        end
        exp_q.delete();
        @(negedge clk);
        bus.din_valid = 1'b0;
        rst_n = 1'b1;
        fill_random();
        run_frame(1'b0, 100, 0, "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/relu_maxpool.md
RELU_MAXPOOL -- requirements
Module: relu_maxpool

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning sample width (signed Q5.10 fixed point).
REQ-002 The block SHALL have parameter FM_W, default 10, meaning input feature-map width (even, >=2).
REQ-003 The block SHALL have parameter FM_H, default 10, meaning input feature-map height (even, >=2).
REQ-004 The block SHALL have parameter FM_C, default 12, meaning channels per frame.
REQ-005 The block SHALL have port clk, input, 1 bit, meaning clock; all logic is rising-edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit, meaning reset, asynchronous, active-low.
REQ-007 The block SHALL have port relu_en, input, 1 bit, meaning clamp negatives to 0; held stable for a whole frame.
REQ-008 The block SHALL have port din_valid, input, 1 bit, meaning upstream conv-core output sample valid.
REQ-009 The block SHALL have port din_ready, output, 1 bit, meaning the block accepts din this cycle.
REQ-010 The block SHALL have port din_data, input, DATA_W bits, meaning signed sample, order channel-major, then row, then column.
REQ-011 The block SHALL have port dout_valid, output, 1 bit, meaning pooled sample valid.
REQ-012 The block SHALL have port dout_ready, input, 1 bit, meaning downstream accepts dout.
REQ-013 The block SHALL have port dout_data, output, DATA_W bits, meaning pooled signed sample, order channel, row, column.
REQ-014 The block SHALL have port dout_last, output, 1 bit, meaning qualifies the final pooled beat of a frame.

Function
REQ-015 The block SHALL count a transfer as accepted on every cycle with din_valid && din_ready.
REQ-016 The block SHALL hold the output beat while dout_valid && !dout_ready, with dout_data and dout_last stable.
REQ-017 The block SHALL drive din_ready = !dout_valid || dout_ready, a combinational stall only.
REQ-018 The block SHALL keep column, row and channel counters that advance on each accepted sample.
REQ-019 Column SHALL wrap FM_W-1 -> 0 and increment row; row SHALL wrap FM_H-1 -> 0 and increment channel; channel SHALL wrap FM_C-1 -> 0 (frame end).
REQ-020 The block SHALL apply ReLU to every accepted sample when relu_en = 1 (value < 0 -> 0); otherwise it SHALL pass samples unchanged.
REQ-021 The FSM SHALL have states ROW_EVEN and ROW_ODD, reset to ROW_EVEN, and SHALL toggle on each row wrap.
REQ-022 In ROW_EVEN, the block SHALL latch the sample at an even column into pair_reg.
REQ-023 In ROW_EVEN, at an odd column the block SHALL write signed max(pair_reg, sample) to line buffer entry col/2, which holds FM_W/2 entries.
REQ-024 In ROW_ODD, at an odd column the block SHALL load dout_data with signed max(pair_reg, sample, linebuf[col/2]) and set dout_valid on the next edge.
REQ-025 Latency SHALL be 1 cycle from the accepted 4th window sample to dout_valid.
REQ-026 All comparisons SHALL be signed DATA_W-bit comparisons with no rounding or saturation; the output width SHALL equal the input width.
REQ-027 The block SHALL assert dout_last with the beat for channel FM_C-1, pooled row FM_H/2-1, pooled column FM_W/2-1.
REQ-028 When a new beat is produced in the same cycle the prior beat is accepted, the new beat SHALL replace it with no bubble.
REQ-029 Per frame, the block SHALL emit exactly FM_C*(FM_H/2)*(FM_W/2) beats, which is 300 at the defaults.
REQ-030 The line buffer SHALL not be cleared between channels; every entry is rewritten before it is read.

Reset
REQ-031 Asserting rst_n low SHALL immediately clear dout_valid=0, dout_last=0, dout_data=0, all counters=0, pair_reg=0 and the state to ROW_EVEN.
REQ-032 Line buffer contents SHALL not require reset.
REQ-033 Reset mid-frame SHALL discard the partial frame; the first sample after release SHALL be treated as channel 0, row 0, column 0.

Structure
REQ-034 DATA_W, FM_W, FM_H, FM_C defaults and the state enum SHALL live in shared package conv_pkg, which is shared with the conv core.
REQ-035 The line buffer SHALL be the single sub-module pool_linebuf: FM_W/2 x DATA_W, 1 write port, 1 async read port.
REQ-036 An elaboration-time check SHALL reject odd FM_W or odd FM_H.

Verification
REQ-037 The bench SHALL check: relu_en=0, frame of ramp values v=c*100+h*10+w, dout_ready=1 -> 300 beats, beat (c,i,j) = c*100+(2i+1)*10+2j+1, dout_last only on beat 300.
REQ-038 The bench SHALL check: relu_en=1, all samples 16'hFC00 (-1.0) -> every beat 0.
REQ-039 The bench SHALL check: relu_en=0, one 2x2 window {-5,-3,-7,-2}, rest -100 -> that beat -2, others -100 (signed compare).
REQ-040 The bench SHALL check: dout_ready held 0 for 20 cycles after the first beat -> din_ready=0, dout_data stable, no sample lost; release -> correct sequence resumes.
REQ-041 The bench SHALL check: din_valid random 50% and dout_ready random 50% over 3 frames -> output matches the reference model beat-for-beat.
REQ-042 The bench SHALL check: rst_n pulsed low after 137 samples, then a full frame -> dout_valid=0 during reset, then exactly 300 correct beats.
